// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-stage branch predictor plus execute-stage branch resolver.
//
// A direct-mapped table of ENTRIES entries holds, per entry, a valid bit, an
// address tag, a predicted target and a 2-bit saturating counter. Fetch looks
// the table up combinationally; execute resolves conditional branches
// (BEQ/BNE/BLT/BGE/BLTU/BGEU), raises a registered mispredict/redirect, trains
// the table and keeps wrapping performance counters.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   fetch_pc       in   XLEN   PC being fetched
//   pred_taken     out  1      predicted taken (combinational)
//   pred_target    out  XLEN   predicted next PC (combinational)
//   resolve_valid  in   1      a conditional branch resolves this cycle
//   resolve_pc     in   XLEN   PC of the resolving branch
//   rs1_data       in   XLEN   operand 1
//   rs2_data       in   XLEN   operand 2
//   immediate      in   XLEN   sign-extended byte offset
//   func3          in   3      branch condition code
//   resolve_pred   in   1      prediction carried down the pipe
//   resolve_ptgt   in   XLEN   predicted target carried down the pipe
//   flush_table    in   1      invalidate every entry
//   mispredict     out  1      registered one-cycle pulse
//   redirect_pc    out  XLEN   registered correct next PC
//   illegal_cond   out  1      registered pulse for func3 010/011
//   branch_count   out  CNT_W  resolved branches (wraps)
//   mispred_count  out  CNT_W  mispredicts (wraps)
//
// ENTRIES must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             resolve_valid,
    input  logic [XLEN-1:0]  resolve_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  immediate,
    input  logic [2:0]       func3,
    input  logic             resolve_pred,
    input  logic [XLEN-1:0]  resolve_ptgt,
    input  logic             flush_table,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_cond,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    // -----------------------------------------------------------------------
    // Table read views (one element per entry, driven from g_entry)
    // -----------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_all;
    logic [TAG_W-1:0]   tag_all    [ENTRIES];
    logic [XLEN-1:0]    target_all [ENTRIES];
    logic [1:0]         ctr_all    [ENTRIES];

    // -----------------------------------------------------------------------
    // Predict
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_tag   = fetch_pc[XLEN-1:IDX_W+2];
    assign fetch_hit   = valid_all[fetch_idx] && (tag_all[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && ctr_all[fetch_idx][1];
    assign pred_target = pred_taken ? target_all[fetch_idx] : fetch_pc + XLEN'(4);

    // -----------------------------------------------------------------------
    // Resolve
    // -----------------------------------------------------------------------
    logic             cond_legal;
    logic             cond_taken;
    logic             actual_taken;
    logic [XLEN-1:0]  res_tgt;
    logic [XLEN-1:0]  res_next;
    logic             mispredict_next;

    always_comb begin
        cond_legal = 1'b1;
        cond_taken = 1'b0;
        case (func3)
            F3_BEQ:  cond_taken = (rs1_data == rs2_data);
            F3_BNE:  cond_taken = (rs1_data != rs2_data);
            F3_BLT:  cond_taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  cond_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: cond_taken = (rs1_data <  rs2_data);
            F3_BGEU: cond_taken = (rs1_data >= rs2_data);
            default: cond_legal = 1'b0;
        endcase
    end

    // Illegal codes resolve as not-taken so the pipe still gets a sane redirect.
    assign actual_taken = cond_legal && cond_taken;
    assign res_tgt      = resolve_pc + immediate;
    assign res_next     = actual_taken ? res_tgt : resolve_pc + XLEN'(4);

    // A taken branch predicted taken still mispredicts if the carried target is stale.
    assign mispredict_next = (actual_taken != resolve_pred) ||
                             (actual_taken && (resolve_ptgt != res_tgt));

    // -----------------------------------------------------------------------
    // Training
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic             train_en;
    logic [1:0]       res_ctr;
    logic [1:0]       ctr_trained;

    assign res_idx  = resolve_pc[IDX_W+1:2];
    assign res_tag  = resolve_pc[XLEN-1:IDX_W+2];
    assign res_hit  = valid_all[res_idx] && (tag_all[res_idx] == res_tag);
    assign train_en = resolve_valid && cond_legal;
    assign res_ctr  = ctr_all[res_idx];

    always_comb begin
        ctr_trained = res_ctr;
        if (actual_taken) begin
            if (res_ctr != 2'b11) begin
                ctr_trained = res_ctr + 2'd1;
            end
        end else begin
            if (res_ctr != 2'b00) begin
                ctr_trained = res_ctr - 2'd1;
            end
        end
    end

    // One register set per entry. Fetch reads the registered state, so a
    // lookup that coincides with a write to the same index sees the old entry.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [XLEN-1:0]  target_reg;
            logic [1:0]       ctr_reg;
            logic             write_sel;

            assign write_sel = train_en && (res_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_RESET;
                end else if (flush_table) begin
                    // Flush wins over any training write this cycle.
                    valid_reg <= 1'b0;
                    ctr_reg   <= CTR_RESET;
                end else if (write_sel) begin
                    if (res_hit) begin
                        ctr_reg <= ctr_trained;
                        if (actual_taken) begin
                            target_reg <= res_tgt;
                        end
                    end else if (actual_taken) begin
                        // Allocate (possibly evicting an alias) only on taken.
                        valid_reg  <= 1'b1;
                        tag_reg    <= res_tag;
                        target_reg <= res_tgt;
                        ctr_reg    <= CTR_ALLOC;
                    end
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign ctr_all[gi]    = ctr_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registered resolve outputs and performance counters
    // -----------------------------------------------------------------------
    logic             mispredict_reg;
    logic [XLEN-1:0]  redirect_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] branch_cnt_reg;
    logic [CNT_W-1:0] mispred_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_reg  <= 1'b0;
            redirect_reg    <= '0;
            illegal_reg     <= 1'b0;
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            mispredict_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            if (resolve_valid) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
                illegal_reg    <= !cond_legal;
                if (mispredict_next) begin
                    mispredict_reg  <= 1'b1;
                    redirect_reg    <= res_next;
                    mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign mispredict    = mispredict_reg;
    assign redirect_pc   = redirect_reg;
    assign illegal_cond  = illegal_reg;
    assign branch_count  = branch_cnt_reg;
    assign mispred_count = mispred_cnt_reg;

    // Instructions are word aligned; the low PC bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], resolve_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
`timescale 1ns/1ps
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             resolve_valid;
    logic [XLEN-1:0]  resolve_pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  immediate;
    logic [2:0]       func3;
    logic             resolve_pred;
    logic [XLEN-1:0]  resolve_ptgt;
    logic             flush_table;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             illegal_cond;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .resolve_valid (resolve_valid),
        .resolve_pc    (resolve_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .immediate     (immediate),
        .func3         (func3),
        .resolve_pred  (resolve_pred),
        .resolve_ptgt  (resolve_ptgt),
        .flush_table   (flush_table),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .illegal_cond  (illegal_cond),
        .branch_count  (branch_count),
        .mispred_count (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [2:0] f3,
                               input logic pred, input logic [31:0] ptgt);
        resolve_valid = 1'b1;
        resolve_pc    = pc;
        rs1_data      = a;
        rs2_data      = b;
        immediate     = imm;
        func3         = f3;
        resolve_pred  = pred;
        resolve_ptgt  = ptgt;
    endtask

    // Advance one edge, then sample 1 ns later and retire the one-cycle inputs.
    task automatic step();
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
        flush_table   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
        checks++; if (mispredict !== 1'b0 || illegal_cond !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL reset_outputs got mp=%0b ill=%0b red=%h want 0/0/0", mispredict, illegal_cond, redirect_pc); end
        checks++; if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL reset_counters got br=%0d mp=%0d want 0/0", branch_count, mispred_count); end
        #2 rst_n = 1'b1;
        step();
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++; $display("FAIL post_reset_pred got %0b/%h want 0/00000104", pred_taken, pred_target); end
        $display("test_reset: pred=%0b tgt=%h br=%0d mp=%0d", pred_taken, pred_target, branch_count, mispred_count);
    endtask

    task automatic test_allocate();
        set_resolve(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b0, 32'h104);
        step();
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h120) begin
            errors++; $display("FAIL alloc_mispredict got %0b/%h want 1/00000120", mispredict, redirect_pc); end
        checks++; if (mispred_count !== 16'd1 || branch_count !== 16'd1) begin
            errors++; $display("FAIL alloc_counters got br=%0d mp=%0d want 1/1", branch_count, mispred_count); end
        fetch_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
            errors++; $display("FAIL alloc_predict got %0b/%h want 1/00000120", pred_taken, pred_target); end
        step();
        checks++; if (mispredict !== 1'b0 || redirect_pc !== 32'h120) begin
            errors++; $display("FAIL pulse_end got %0b/%h want 0/00000120", mispredict, redirect_pc); end
        $display("test_allocate: redirect=%h br=%0d mp=%0d", redirect_pc, branch_count, mispred_count);
    endtask

    // Counter walk for PC 0x100 starting at ctr=10: NT, NT, NT(saturate at 00), T, T.
    task automatic test_counter();
        logic [2:0]  f3_t   [5] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic        pred_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] ptgt_t [5] = '{32'h120, 32'h104, 32'h104, 32'h104, 32'h104};
        logic        mp_t   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] red_t  [5] = '{32'h104, 32'h104, 32'h104, 32'h120, 32'h120};
        logic        pt_t   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ptg_t  [5] = '{32'h104, 32'h104, 32'h104, 32'h104, 32'h120};
        for (int i = 0; i < 5; i++) begin
            set_resolve(32'h100, 32'd5, 32'd5, 32'h20, f3_t[i], pred_t[i], ptgt_t[i]);
            step();
            checks++; if (mispredict !== mp_t[i] || redirect_pc !== red_t[i]) begin
                errors++; $display("FAIL ctr_resolve[%0d] got %0b/%h want %0b/%h", i, mispredict, redirect_pc, mp_t[i], red_t[i]); end
            fetch_pc = 32'h100; #1;
            checks++; if (pred_taken !== pt_t[i] || pred_target !== ptg_t[i]) begin
                errors++; $display("FAIL ctr_predict[%0d] got %0b/%h want %0b/%h", i, pred_taken, pred_target, pt_t[i], ptg_t[i]); end
            $display("test_counter[%0d]: mp=%0b red=%h pred=%0b tgt=%h", i, mispredict, redirect_pc, pred_taken, pred_target);
        end
        checks++; if (branch_count !== 16'd6 || mispred_count !== 16'd4) begin
            errors++; $display("FAIL ctr_counters got br=%0d mp=%0d want 6/4", branch_count, mispred_count); end
    endtask

    // All resolved with resolve_pred=0, so mispredict equals actual taken.
    task automatic test_conditions();
        logic [31:0] pc_t  [9] = '{32'h208, 32'h208, 32'h208, 32'h208, 32'h208, 32'h208, 32'hFFFFFFF0, 32'h208, 32'h208};
        logic [31:0] a_t   [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd7, 32'd1, 32'd3};
        logic [31:0] b_t   [9] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd6, 32'd6, 32'd7, 32'd2, 32'd3};
        logic [31:0] imm_t [9] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h80, 32'h80, 32'h20, 32'hFFFFFFF8, 32'h40};
        logic [2:0]  f3_t  [9] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101};
        logic        tk_t  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] red_t [9] = '{32'h248, 32'h248, 32'h248, 32'h248, 32'h288, 32'h288, 32'h10, 32'h200, 32'h248};
        for (int i = 0; i < 9; i++) begin
            set_resolve(pc_t[i], a_t[i], b_t[i], imm_t[i], f3_t[i], 1'b0, pc_t[i] + 32'd4);
            step();
            checks++; if (mispredict !== tk_t[i] || redirect_pc !== red_t[i]) begin
                errors++; $display("FAIL cond[%0d] f3=%b got %0b/%h want %0b/%h", i, f3_t[i], mispredict, redirect_pc, tk_t[i], red_t[i]); end
            $display("test_conditions[%0d]: f3=%b mp=%0b red=%h", i, f3_t[i], mispredict, redirect_pc);
        end
        // Taken and predicted taken, but with a stale target.
        set_resolve(32'h208, 32'd5, 32'd5, 32'h40, 3'b000, 1'b1, 32'h244);
        step();
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h248) begin
            errors++; $display("FAIL stale_target got %0b/%h want 1/00000248", mispredict, redirect_pc); end
        set_resolve(32'h208, 32'd5, 32'd5, 32'h40, 3'b000, 1'b1, 32'h248);
        step();
        checks++; if (mispredict !== 1'b0) begin
            errors++; $display("FAIL correct_target got %0b want 0", mispredict); end
        checks++; if (branch_count !== 16'd17 || mispred_count !== 16'd11) begin
            errors++; $display("FAIL cond_counters got br=%0d mp=%0d want 17/11", branch_count, mispred_count); end
    endtask

    // 0x100 and 0x140 share index 0 with different tags.
    task automatic test_aliasing();
        set_resolve(32'h140, 32'd5, 32'd5, 32'h10, 3'b001, 1'b0, 32'h144);
        step();
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL alias_nt_mp got %0b want 0", mispredict); end
        fetch_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
            errors++; $display("FAIL alias_nt_keep got %0b/%h want 1/00000120", pred_taken, pred_target); end
        fetch_pc = 32'h140; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
            errors++; $display("FAIL alias_nt_miss got %0b/%h want 0/00000144", pred_taken, pred_target); end
        // Same-cycle fetch of the index being written returns the old entry.
        set_resolve(32'h140, 32'd5, 32'd5, 32'h10, 3'b000, 1'b0, 32'h144);
        fetch_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
            errors++; $display("FAIL same_cycle_read got %0b/%h want 1/00000120", pred_taken, pred_target); end
        step();
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h150) begin
            errors++; $display("FAIL alias_t_mp got %0b/%h want 1/00000150", mispredict, redirect_pc); end
        fetch_pc = 32'h140; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h150) begin
            errors++; $display("FAIL alias_t_hit got %0b/%h want 1/00000150", pred_taken, pred_target); end
        fetch_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++; $display("FAIL alias_evicted got %0b/%h want 0/00000104", pred_taken, pred_target); end
        $display("test_aliasing: br=%0d mp=%0d", branch_count, mispred_count);
    endtask

    task automatic test_illegal_flush_reset();
        // Illegal code on a hitting entry: resolves not-taken but must not train.
        set_resolve(32'h140, 32'd5, 32'd5, 32'h10, 3'b010, 1'b1, 32'h150);
        step();
        checks++; if (illegal_cond !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 32'h144) begin
            errors++; $display("FAIL illegal_010 got ill=%0b mp=%0b red=%h want 1/1/00000144", illegal_cond, mispredict, redirect_pc); end
        fetch_pc = 32'h140; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h150) begin
            errors++; $display("FAIL illegal_no_write got %0b/%h want 1/00000150", pred_taken, pred_target); end
        set_resolve(32'h140, 32'd5, 32'd5, 32'h10, 3'b011, 1'b0, 32'h144);
        step();
        checks++; if (illegal_cond !== 1'b1 || mispredict !== 1'b0) begin
            errors++; $display("FAIL illegal_011 got ill=%0b mp=%0b want 1/0", illegal_cond, mispredict); end
        step();
        checks++; if (illegal_cond !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end got %0b want 0", illegal_cond); end
        checks++; if (branch_count !== 16'd21 || mispred_count !== 16'd13) begin
            errors++; $display("FAIL illegal_counters got br=%0d mp=%0d want 21/13", branch_count, mispred_count); end

        // Flush with a taken resolve in the same cycle.
        set_resolve(32'h208, 32'd5, 32'd5, 32'h40, 3'b000, 1'b0, 32'h20C);
        flush_table = 1'b1;
        step();
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h248) begin
            errors++; $display("FAIL flush_mp got %0b/%h want 1/00000248", mispredict, redirect_pc); end
        checks++; if (branch_count !== 16'd22 || mispred_count !== 16'd14) begin
            errors++; $display("FAIL flush_counters got br=%0d mp=%0d want 22/14", branch_count, mispred_count); end
        fetch_pc = 32'h140; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
            errors++; $display("FAIL flush_miss_140 got %0b/%h want 0/00000144", pred_taken, pred_target); end
        fetch_pc = 32'h208; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h20C) begin
            errors++; $display("FAIL flush_miss_208 got %0b/%h want 0/0000020c", pred_taken, pred_target); end
        fetch_pc = 32'hFFFFFFF0; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'hFFFFFFF4) begin
            errors++; $display("FAIL flush_miss_fff0 got %0b/%h want 0/fffffff4", pred_taken, pred_target); end
        $display("test_flush: br=%0d mp=%0d", branch_count, mispred_count);

        // Asynchronous reset while a mispredict pulse is showing.
        set_resolve(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b0, 32'h104);
        step();
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL pre_reset_mp got %0b want 1", mispredict); end
        fetch_pc = 32'h100;
        rst_n = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b0 || illegal_cond !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL async_reset_out got mp=%0b ill=%0b red=%h want 0/0/0", mispredict, illegal_cond, redirect_pc); end
        checks++; if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL async_reset_cnt got br=%0d mp=%0d want 0/0", branch_count, mispred_count); end
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++; $display("FAIL async_reset_table got %0b/%h want 0/00000104", pred_taken, pred_target); end
        #2 rst_n = 1'b1;
        step();
        checks++; if (mispredict !== 1'b0 || branch_count !== 16'd0) begin
            errors++; $display("FAIL after_reset got mp=%0b br=%0d want 0/0", mispredict, branch_count); end
        $display("test_async_reset: mp=%0b br=%0d", mispredict, branch_count);
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_pc      = '0;
        resolve_valid = 1'b0;
        resolve_pc    = '0;
        rs1_data      = '0;
        rs2_data      = '0;
        immediate     = '0;
        func3         = 3'b000;
        resolve_pred  = 1'b0;
        resolve_ptgt  = '0;
        flush_table   = 1'b0;

        test_reset();
        test_allocate();
        test_counter();
        test_conditions();
        test_aliasing();
        test_illegal_flush_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
